// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the CPU external memory bus.
// ContralBus bit positions, access-size and responder-state encodings,
// and small decode helpers used by the responder and its lane formatter.
package mem_bus_pkg;

  // ContralBus = {MemWrite, Memrhalf, Memrbyte, MemExt}
  localparam int unsigned CB_WRITE = 3;
  localparam int unsigned CB_HALF  = 2;
  localparam int unsigned CB_BYTE  = 1;
  localparam int unsigned CB_EXT   = 0;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RMW_WR,
    ST_DONE
  } state_e;

  // Byte select has priority over halfword select.
  function automatic size_e decode_size(input logic [3:0] cb);
    if (cb[CB_BYTE]) return SZ_BYTE;
    if (cb[CB_HALF]) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_WORD: return lo != 2'b00;
      SZ_HALF: return lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU external memory bus (address, data, control, status).
// master = CPU side, slave = memory responder side.
interface mem_responder_if;
  logic [31:0] AddressBus;
  logic [31:0] DataBusOut;
  logic [3:0]  ContralBus;
  logic [31:0] DataBusIn;
  logic        ready;
  logic        err;
  logic        err_clr;

  modport master (
    output AddressBus, DataBusOut, ContralBus, err_clr,
    input  DataBusIn, ready, err
  );

  modport slave (
    input  AddressBus, DataBusOut, ContralBus, err_clr,
    output DataBusIn, ready, err
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational little-endian lane logic.
// Extracts and sign/zero-extends byte/half/word loads, and merges store data
// into the addressed lane(s) of a read word for read-modify-write.
module mem_lane_fmt
  import mem_bus_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Load path: select lane, then extend to 32 bits.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{ext & half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Store path: replace the addressed lane(s) with the low bits of wdata.
  always_comb begin
    store_word = rd_word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the single-cycle CPU bus.
// Synchronous word RAM; each distinct request {addr, control, store data}
// executes once and is acknowledged through ready. Sub-word stores use
// read-modify-write. Misaligned/out-of-range accesses return 0 / drop the
// store and set the sticky err flag.
// Optional feature macro: MEM_PROTECT_EN (reject stores below PROTECT_TOP).
module mem_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] PROTECT_TOP = 32'h0000_0400
) (
  input  logic           clk_,
  input  logic           init,
  mem_responder_if.slave bus
);

  localparam int unsigned KEY_W = 68;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e            state;
  logic [KEY_W-1:0]  live_key;
  logic [KEY_W-1:0]  lat_key;
  logic [KEY_W-1:0]  done_key;
  logic              done_valid;
  logic              key_match;
  logic              start;
  logic [3:0]        wcnt;
  logic [31:0]       rd_word;
  logic [31:0]       lat_addr;
  logic [3:0]        lat_cb;
  logic [31:0]       lat_wdata;
  logic              lat_write;
  size_e             lat_size;
  logic              lat_bad;
  logic              prot_hit;
  logic              drop_store;
  logic              err_set;
  logic              mem_we;
  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic [ADDR_W-1:0] live_idx;
  logic [ADDR_W-1:0] lat_idx;
  logic [31:0]       mem [DEPTH];

  // Store data only distinguishes requests when MemWrite is set.
  assign live_key  = {bus.AddressBus, bus.ContralBus,
                      bus.ContralBus[CB_WRITE] ? bus.DataBusOut : 32'h0};
  assign key_match = done_valid && (live_key == done_key);
  assign start     = ((state == ST_IDLE) || (state == ST_DONE)) && !key_match;
  assign bus.ready = (state == ST_DONE) && key_match;

  assign lat_addr  = lat_key[67:36];
  assign lat_cb    = lat_key[35:32];
  assign lat_wdata = lat_key[31:0];
  assign lat_write = lat_cb[CB_WRITE];
  assign lat_size  = decode_size(lat_cb);
  assign live_idx  = bus.AddressBus[ADDR_W+1:2];
  assign lat_idx   = lat_addr[ADDR_W+1:2];
  assign lat_bad   = is_misaligned(lat_size, lat_addr[1:0]) ||
                     ((lat_addr >> (ADDR_W + 2)) != 32'h0);

`ifdef MEM_PROTECT_EN
  assign prot_hit = lat_write && (lat_addr < PROTECT_TOP);
`else
  // Protection disabled: PROTECT_TOP has no effect, the term folds to 0.
  assign prot_hit = 1'b0 && (lat_addr < PROTECT_TOP);
`endif

  assign drop_store = lat_bad || prot_hit;
  // Gating with init aborts a pending RMW write while reset is held.
  assign mem_we     = (state == ST_RMW_WR) && !drop_store && init;
  assign err_set    = ((state == ST_WAIT) && (wcnt == 4'd0) && !lat_write && lat_bad) ||
                      ((state == ST_RMW_WR) && drop_store);

  mem_lane_fmt u_lane (
    .rd_word    (rd_word),
    .addr_lo    (lat_addr[1:0]),
    .size       (lat_size),
    .ext        (lat_cb[CB_EXT]),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // RAM array: merged write in RMW_WR, word read when a new request starts.
  always_ff @(posedge clk_) begin
    if (mem_we) mem[lat_idx] <= store_word;
    if (start)  rd_word <= mem[live_idx];
  end

  // Request sequencer, load data register and sticky error flag.
  always_ff @(posedge clk_ or negedge init) begin
    if (!init) begin
      state         <= ST_IDLE;
      lat_key       <= '0;
      done_key      <= '0;
      done_valid    <= 1'b0;
      wcnt          <= '0;
      bus.DataBusIn <= '0;
      bus.err       <= 1'b0;
    end else begin
      if (err_set)          bus.err <= 1'b1;
      else if (bus.err_clr) bus.err <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (!key_match) begin
            lat_key <= live_key;
            wcnt    <= 4'(WAIT_STATES);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else if (lat_write) begin
            state <= ST_RMW_WR;
          end else begin
            bus.DataBusIn <= lat_bad ? 32'h0 : load_data;
            done_key      <= lat_key;
            done_valid    <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_RMW_WR: begin
          done_key   <= lat_key;
          done_valid <= 1'b1;
          state      <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder.
// Directed cases plus randomized requests against a byte-lane arithmetic
// model; a second instance with WAIT_STATES=3 covers reset during a store.
// Honours MEM_PROTECT_EN when the design is built with it.
module tb_mem_responder;

  localparam logic [3:0] LW  = 4'b0000;
  localparam logic [3:0] LHU = 4'b0100;
  localparam logic [3:0] LH  = 4'b0101;
  localparam logic [3:0] LBU = 4'b0010;
  localparam logic [3:0] LB  = 4'b0011;
  localparam logic [3:0] SW  = 4'b1000;
  localparam logic [3:0] SH  = 4'b1100;
  localparam logic [3:0] SB  = 4'b1010;
  localparam int unsigned WS        = 0;
  localparam logic [31:0] MEM_BYTES = 32'h0000_1000;
  localparam logic [31:0] RBASE     = 32'h0000_0800;
`ifdef MEM_PROTECT_EN
  localparam logic [31:0] BASE = 32'h0000_0400;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif

  logic clk_  = 1'b0;
  logic init  = 1'b0;
  logic init3 = 1'b0;
  always #5 clk_ = ~clk_;

  mem_responder_if bus ();
  mem_responder_if bus3 ();

  mem_responder #(.ADDR_W(10), .WAIT_STATES(WS), .PROTECT_TOP(32'h0000_0400)) dut (
    .clk_ (clk_),
    .init (init),
    .bus  (bus)
  );

  mem_responder #(.ADDR_W(10), .WAIT_STATES(3), .PROTECT_TOP(32'h0000_0400)) dut3 (
    .clk_ (clk_),
    .init (init3),
    .bus  (bus3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;

  logic [31:0] mdl_mem [int unsigned];
  logic [31:0] exp_dbi    = '0;
  logic        exp_err    = 1'b0;
  logic [67:0] last_key   = '0;
  bit          last_valid = 1'b0;

  always @(posedge clk_) if (dut.mem_we === 1'b1) we_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input int unsigned sh,
                                           input int unsigned nb, input bit ext);
    logic [31:0] mask, v;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v = (w >> sh) & mask;
    if (ext && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Issue one request, wait for ready (bounded), compare against the model.
  task automatic req(input logic [31:0] a, input logic [3:0] cb, input logic [31:0] wd,
                     input string tag, output logic [31:0] got);
    logic [67:0] key;
    bit same, bad;
    int unsigned nb, sh, widx, edges, exp_edges;
    logic [31:0] mask, w;
    key  = {a, cb, cb[3] ? wd : 32'h0};
    same = last_valid && (key == last_key);
    nb   = cb[1] ? 1 : (cb[2] ? 2 : 4);
    sh   = 8 * int'(a[1:0]);
    widx = int'(a[11:2]);
    bad  = ((a % nb) != 0) || (a >= MEM_BYTES);
`ifdef MEM_PROTECT_EN
    if (cb[3] && a < 32'h0000_0400) bad = 1'b1;
`endif
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);

    bus.AddressBus = a;
    bus.ContralBus = cb;
    bus.DataBusOut = wd;
    #1;
    if (!same) check_eq({tag, "_rdy0"}, {31'h0, bus.ready}, 32'h0);
    edges = 0;
    while (!bus.ready && edges < 40) begin
      @(posedge clk_);
      #1;
      edges++;
    end

    exp_edges = 0;
    if (!same) begin
      exp_edges = (cb[3] ? 3 : 2) + WS;
      if (cb[3]) begin
        if (!bad) begin
          w = mdl_mem[widx];
          mdl_mem[widx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
        end
      end else begin
        exp_dbi = bad ? 32'h0 : mdl_load(mdl_mem[widx], sh, nb, cb[0]);
      end
      if (bad) exp_err = 1'b1;
    end
    check_eq({tag, "_lat"}, edges, exp_edges);
    check_eq({tag, "_data"}, bus.DataBusIn, exp_dbi);
    check_eq({tag, "_err"}, {31'h0, bus.err}, {31'h0, exp_err});
    got        = bus.DataBusIn;
    last_key   = key;
    last_valid = 1'b1;
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    @(posedge clk_);
    #1;
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    check_eq("err_clr", {31'h0, bus.err}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, ra, rwd;
    logic [3:0]  rcb;
    logic [3:0]  cb_tab [10];
    int wc, edges;
    cb_tab = '{LW, LH, LHU, LB, LBU, 4'b0110, SW, SH, SB, 4'b1110};

    bus.AddressBus  = BASE + 32'hFC;
    bus.ContralBus  = SW;
    bus.DataBusOut  = 32'h0;
    bus.err_clr     = 1'b0;
    bus3.AddressBus = 32'h80;
    bus3.ContralBus = SW;
    bus3.DataBusOut = 32'h5A5A_5A5A;
    bus3.err_clr    = 1'b0;
    #12;
    check_eq("rst_ready", {31'h0, bus.ready}, 32'h0);
    check_eq("rst_data", bus.DataBusIn, 32'h0);
    check_eq("rst_err", {31'h0, bus.err}, 32'h0);
    @(posedge clk_);
    #1;
    init  = 1'b1;
    init3 = 1'b1;

    // Word store then load.
    req(BASE + 32'h10, SW, 32'h1122_3344, "sw10", got);
    req(BASE + 32'h10, LW, 32'h0, "lw10", got);
    check_eq("lw10_val", got, 32'h1122_3344);

    // Sub-word loads with extension.
    req(BASE + 32'h20, SW, 32'h80FF_7F01, "sw20", got);
    req(BASE + 32'h21, LB, 32'h0, "lb21", got);
    check_eq("lb21_val", got, 32'h0000_007F);
    req(BASE + 32'h23, LB, 32'h0, "lb23", got);
    check_eq("lb23_val", got, 32'hFFFF_FF80);
    req(BASE + 32'h22, LHU, 32'h0, "lhu22", got);
    check_eq("lhu22_val", got, 32'h0000_80FF);
    req(BASE + 32'h22, LH, 32'h0, "lh22", got);
    check_eq("lh22_val", got, 32'hFFFF_80FF);

    // Sub-word stores.
    req(BASE + 32'h30, SW, 32'hAABB_CCDD, "sw30", got);
    req(BASE + 32'h31, SB, 32'h0000_0055, "sb31", got);
    req(BASE + 32'h30, LW, 32'h0, "lw30a", got);
    check_eq("lw30a_val", got, 32'hAABB_55DD);
    req(BASE + 32'h32, SH, 32'h0000_1234, "sh32", got);
    req(BASE + 32'h30, LW, 32'h0, "lw30b", got);
    check_eq("lw30b_val", got, 32'h1234_55DD);

    // A held store commits once; re-issued after another request it commits again.
    req(BASE + 32'h40, SW, 32'h0, "sw40", got);
    wc = we_cnt;
    req(BASE + 32'h40, SB, 32'h01, "sb40", got);
    repeat (20) @(posedge clk_);
    #1;
    check_eq("wonce_cnt", we_cnt - wc, 32'd1);
    check_eq("wonce_rdy", {31'h0, bus.ready}, 32'h1);
    req(BASE + 32'h40, LW, 32'h0, "lw40", got);
    check_eq("lw40_val", got, 32'h0000_0001);
    req(BASE + 32'h40, SB, 32'h01, "sb40b", got);
    check_eq("reissue_cnt", we_cnt - wc, 32'd2);

    // Error responses.
    req(BASE + 32'h0, SW, 32'hCAFE_F00D, "sw00", got);
    req(BASE + 32'h42, LW, 32'h0, "lw42", got);
    check_eq("lw42_val", got, 32'h0);
    check_eq("lw42_errset", {31'h0, bus.err}, 32'h1);
    wc = we_cnt;
    req(BASE + 32'h0010_0000, SW, 32'hDEAD_BEEF, "sw_oor", got);
    check_eq("sw_oor_we", we_cnt - wc, 32'd0);
    req(BASE + 32'h0, LW, 32'h0, "lw00", got);
    check_eq("lw00_val", got, 32'hCAFE_F00D);
    clear_err();
`ifdef MEM_PROTECT_EN
    wc = we_cnt;
    req(32'h100, SW, 32'h1234_5678, "sw_prot", got);
    check_eq("sw_prot_we", we_cnt - wc, 32'd0);
    check_eq("sw_prot_err", {31'h0, bus.err}, 32'h1);
    clear_err();
`endif

    // Randomized traffic over 16 words.
    for (int unsigned i = 0; i < 16; i++) req(RBASE + 4 * i, SW, $urandom, "rinit", got);
    ra = RBASE; rcb = LW; rwd = '0;
    for (int unsigned i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) clear_err();
      if (i == 0 || $urandom_range(0, 7) != 0) begin
        ra = RBASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) ra = ra | (32'h1000 << $urandom_range(0, 19));
        rcb = cb_tab[$urandom_range(0, 9)];
        rwd = $urandom;
      end
      req(ra, rcb, rwd, "rnd", got);
    end

    // Reset during the wait phase of a store (WAIT_STATES=3 instance).
    check_eq("r3_prep_rdy", {31'h0, bus3.ready}, 32'h1);
    check_eq("r3_prep_mem", dut3.mem[32], 32'h5A5A_5A5A);
    @(posedge clk_);
    #1;
    bus3.AddressBus = 32'h81;
    bus3.ContralBus = SB;
    bus3.DataBusOut = 32'h0000_00EE;
    @(posedge clk_);
    @(posedge clk_);
    #1;
    init3 = 1'b0;
    #1;
    check_eq("r3_rst_rdy", {31'h0, bus3.ready}, 32'h0);
    check_eq("r3_rst_data", bus3.DataBusIn, 32'h0);
    check_eq("r3_rst_mem", dut3.mem[32], 32'h5A5A_5A5A);
    repeat (8) @(posedge clk_);
    #1;
    check_eq("r3_hold_mem", dut3.mem[32], 32'h5A5A_5A5A);
    check_eq("r3_hold_rdy", {31'h0, bus3.ready}, 32'h0);
    init3 = 1'b1;
    edges = 0;
    while (!bus3.ready && edges < 60) begin
      @(posedge clk_);
      #1;
      edges++;
    end
    check_eq("r3_rel_lat", edges, 32'd6);
    check_eq("r3_rel_mem", dut3.mem[32], 32'h5A5A_EE5A);
    check_eq("r3_rel_data", bus3.DataBusIn, 32'h0);
    check_eq("r3_rel_err", {31'h0, bus3.err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
